// File: rtl/allgates_pkg.sv
// Shared types and constants for the all-gates block and its built-in self-test.
package allgates_pkg;

  localparam int unsigned N_OUT_ALLGATES = 15;

  localparam int unsigned IDX_NOT    = 0;
  localparam int unsigned IDX_AND    = 1;
  localparam int unsigned IDX_NAND   = 2;
  localparam int unsigned IDX_ANDNOT = 3;
  localparam int unsigned IDX_OR     = 4;
  localparam int unsigned IDX_NOR    = 5;
  localparam int unsigned IDX_ORNOT  = 6;
  localparam int unsigned IDX_XOR    = 7;
  localparam int unsigned IDX_XNOR   = 8;
  localparam int unsigned IDX_AOI3   = 9;
  localparam int unsigned IDX_OAI3   = 10;
  localparam int unsigned IDX_AOI4   = 11;
  localparam int unsigned IDX_OAI4   = 12;
  localparam int unsigned IDX_MUX    = 13;
  localparam int unsigned IDX_NMUX   = 14;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } state_e;

endpackage

// File: rtl/allgates_golden.sv
// Combinational reference model of the 4-input / 15-output all-gates block.
module allgates_golden
  import allgates_pkg::*;
(
  input  logic [3:0]                i_stim,
  output logic [N_OUT_ALLGATES-1:0] o_expected
);

  logic w_a, w_b, w_c, w_d, w_mux;

  assign w_a   = i_stim[0];
  assign w_b   = i_stim[1];
  assign w_c   = i_stim[2];
  assign w_d   = i_stim[3];
  assign w_mux = w_c ? w_b : w_a;

  always_comb begin
    o_expected             = '0;
    o_expected[IDX_NOT]    = ~w_a;
    o_expected[IDX_AND]    = w_a & w_b;
    o_expected[IDX_NAND]   = ~(w_a & w_b);
    o_expected[IDX_ANDNOT] = w_a & ~w_b;
    o_expected[IDX_OR]     = w_a | w_b;
    o_expected[IDX_NOR]    = ~(w_a | w_b);
    o_expected[IDX_ORNOT]  = w_a | ~w_b;
    o_expected[IDX_XOR]    = w_a ^ w_b;
    o_expected[IDX_XNOR]   = ~(w_a ^ w_b);
    o_expected[IDX_AOI3]   = ~((w_a & w_b) | w_c);
    o_expected[IDX_OAI3]   = ~((w_a | w_b) & w_c);
    o_expected[IDX_AOI4]   = ~((w_a & w_b) | (w_c & w_d));
    o_expected[IDX_OAI4]   = ~((w_a | w_b) & (w_c | w_d));
    o_expected[IDX_MUX]    = w_mux;
    o_expected[IDX_NMUX]   = ~w_mux;
  end

endmodule

// File: rtl/allgates_bist.sv
// Exhaustive stimulus sweep and response checker for the all-gates block,
// with saturating error count and first-failure capture.
module allgates_bist
  import allgates_pkg::*;
#(
  parameter int unsigned      N_IN         = 4,
  parameter int unsigned      N_OUT        = N_OUT_ALLGATES,
  parameter int unsigned      SETTLE       = 2,
  parameter logic [N_OUT-1:0] CHECK_MASK   = '1,
  parameter bit               STOP_ON_FAIL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [N_IN-1:0]  o_stim,
  input  logic [N_OUT-1:0] i_resp,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [N_IN:0]    o_err_count,
  output logic [N_IN-1:0]  o_fail_vec,
  output logic [N_OUT-1:0] o_fail_mask
);

  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = '1;
  localparam logic [N_IN:0]   ERR_MAX     = '1;

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic [N_IN-1:0]  r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [N_IN:0]    r_err_count;
  logic [N_IN-1:0]  r_fail_vec;
  logic [N_OUT-1:0] r_fail_mask;

  logic [N_OUT-1:0] w_golden;
  logic [N_OUT-1:0] w_mism;
  logic             w_fail;
  logic             w_last;
  logic [N_IN:0]    w_err_next;

  allgates_golden u_golden (
    .i_stim     (r_stim),
    .o_expected (w_golden)
  );

  assign w_mism = (i_resp ^ w_golden) & CHECK_MASK;
  assign w_fail = |w_mism;
  assign w_last = (r_stim == LAST_VEC) || (STOP_ON_FAIL && w_fail);

  always_comb begin
    w_err_next = r_err_count;
    if (w_fail && (r_err_count != ERR_MAX)) begin
      w_err_next = r_err_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_stim      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_vec  <= '0;
      r_fail_mask <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state     <= StSettle;
            r_cnt       <= SETTLE_LOAD;
            r_stim      <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
            r_fail_vec  <= '0;
            r_fail_mask <= '0;
          end
        end
        StSettle: begin
          if (r_cnt == 4'd0) begin
            r_state <= StCheck;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StCheck: begin
          r_err_count <= w_err_next;
          // Count is cleared at start and never wraps, so zero means no failure yet.
          if (w_fail && (r_err_count == '0)) begin
            r_fail_vec  <= r_stim;
            r_fail_mask <= w_mism;
          end
          if (w_last) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state <= StSettle;
            r_stim  <= r_stim + 1'b1;
            r_cnt   <= SETTLE_LOAD;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_stim      = r_stim;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_count = r_err_count;
  assign o_fail_vec  = r_fail_vec;
  assign o_fail_mask = r_fail_mask;

endmodule

// File: tb/tb_allgates_bist.sv
// Directed bench: three checkers (default, masked aoi4, stop-on-fail) beside a faultable DUT model.
module tb_allgates_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  int   mode_a, mode_m, mode_s;
  int   checks, errors;

  logic [3:0]  stim_a, stim_m, stim_s;
  logic [14:0] resp_a, resp_m, resp_s;
  logic        busy_a, done_a, pass_a, busy_m, done_m, pass_m, busy_s, done_s, pass_s;
  logic [4:0]  err_a, err_m, err_s;
  logic [3:0]  fv_a, fv_m, fv_s;
  logic [14:0] fm_a, fm_m, fm_s;

  function automatic logic [14:0] model(input logic [3:0] v);
    logic a, b, c, d;
    logic [14:0] r;
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    r[0]  = ~a;            r[1]  = a & b;         r[2] = ~(a & b);
    r[3]  = a & ~b;        r[4]  = a | b;         r[5] = ~(a | b);
    r[6]  = a | ~b;        r[7]  = a ^ b;         r[8] = ~(a ^ b);
    r[9]  = ~((a & b) | c);
    r[10] = ~((a | b) & c);
    r[11] = ~((a & b) | (c & d));
    r[12] = ~((a | b) & (c | d));
    r[13] = c ? b : a;
    r[14] = ~(c ? b : a);
    return r;
  endfunction

  // 1: xor stuck-at-0, 2: aoi4 inverted at vector 5, 3: nand inverted from vector 3 on
  function automatic logic [14:0] dut_resp(input logic [3:0] v, input int mode);
    logic [14:0] r;
    r = model(v);
    case (mode)
      1: r[7] = 1'b0;
      2: if (v == 4'd5) r[11] = ~r[11];
      3: if (v >= 4'd3) r[2] = ~r[2];
      default: ;
    endcase
    return r;
  endfunction

  assign resp_a = dut_resp(stim_a, mode_a);
  assign resp_m = dut_resp(stim_m, mode_m);
  assign resp_s = dut_resp(stim_s, mode_s);

  allgates_bist u_dut (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start), .o_stim (stim_a), .i_resp (resp_a),
    .o_busy (busy_a), .o_done (done_a), .o_pass (pass_a), .o_err_count (err_a),
    .o_fail_vec (fv_a), .o_fail_mask (fm_a)
  );

  allgates_bist #(.CHECK_MASK (15'h77FF)) u_dut_mask (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start), .o_stim (stim_m), .i_resp (resp_m),
    .o_busy (busy_m), .o_done (done_m), .o_pass (pass_m), .o_err_count (err_m),
    .o_fail_vec (fv_m), .o_fail_mask (fm_m)
  );

  allgates_bist #(.STOP_ON_FAIL (1'b1)) u_dut_sof (
    .i_clk (clk), .i_rst_n (rst_n), .i_start (start), .o_stim (stim_s), .i_resp (resp_s),
    .o_busy (busy_s), .o_done (done_s), .o_pass (pass_s), .o_err_count (err_s),
    .o_fail_vec (fv_s), .o_fail_mask (fm_s)
  );

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({stim_a, busy_a, done_a, pass_a} !== 7'd0) begin errors++;
      $display("FAIL reset_ctrl: got stim=%0h busy=%b done=%b pass=%b expected all 0",
               stim_a, busy_a, done_a, pass_a); end
    checks++; if ({err_a, fv_a, fm_a} !== 24'd0) begin errors++;
      $display("FAIL reset_diag: got err=%0d fv=%0h fm=%0h expected all 0", err_a, fv_a, fm_a); end
  endtask

  task automatic test_clean();
    int cycles = 0;
    bit busy_ok = 1'b1;
    mode_a = 0; mode_m = 0; mode_s = 0;
    pulse_start();
    while (!done_a && cycles < 200) begin
      if (!busy_a) busy_ok = 1'b0;
      @(negedge clk); cycles++;
    end
    checks++; if (cycles !== 48) begin errors++;
      $display("FAIL clean_latency: got %0d cycles expected 48", cycles); end
    checks++; if (!busy_ok || busy_a !== 1'b0) begin errors++;
      $display("FAIL clean_busy: got busy_ok=%b busy_end=%b expected 1/0", busy_ok, busy_a); end
    checks++; if ({pass_a, err_a} !== {1'b1, 5'd0}) begin errors++;
      $display("FAIL clean_pass: got pass=%b err=%0d expected 1/0", pass_a, err_a); end
    repeat (5) @(negedge clk);
    checks++; if ({done_a, stim_a} !== {1'b1, 4'hF}) begin errors++;
      $display("FAIL clean_hold: got done=%b stim=%0h expected 1/f", done_a, stim_a); end
  endtask

  task automatic test_xor_stuck();
    int cycles = 0;
    mode_a = 1;
    pulse_start();
    while (!done_a && cycles < 200) begin @(negedge clk); cycles++; end
    checks++; if (err_a !== 5'd8) begin errors++;
      $display("FAIL xor_err_count: got %0d expected 8", err_a); end
    checks++; if ({fv_a, fm_a} !== {4'h1, 15'h0080}) begin errors++;
      $display("FAIL xor_capture: got fv=%0h fm=%0h expected 1/0080", fv_a, fm_a); end
    checks++; if ({done_a, pass_a} !== 2'b10) begin errors++;
      $display("FAIL xor_pass: got done=%b pass=%b expected 1/0", done_a, pass_a); end
  endtask

  task automatic test_aoi4_masked();
    int cycles = 0;
    mode_a = 2; mode_m = 2;
    pulse_start();
    while (!(done_a && done_m) && cycles < 200) begin @(negedge clk); cycles++; end
    checks++; if ({err_a, fv_a, fm_a} !== {5'd1, 4'h5, 15'h0800}) begin errors++;
      $display("FAIL aoi4_capture: got err=%0d fv=%0h fm=%0h expected 1/5/0800", err_a, fv_a, fm_a); end
    checks++; if ({done_m, pass_m, err_m} !== {2'b11, 5'd0}) begin errors++;
      $display("FAIL aoi4_masked_pass: got done=%b pass=%b err=%0d expected 1/1/0",
               done_m, pass_m, err_m); end
    mode_a = 0; mode_m = 0;
  endtask

  task automatic test_stop_on_fail();
    int cycles = 0;
    mode_s = 3;
    pulse_start();
    while (!done_s && cycles < 200) begin @(negedge clk); cycles++; end
    checks++; if (cycles !== 12) begin errors++;
      $display("FAIL sof_latency: got %0d cycles expected 12", cycles); end
    checks++; if ({err_s, stim_s, pass_s} !== {5'd1, 4'h3, 1'b0}) begin errors++;
      $display("FAIL sof_state: got err=%0d stim=%0h pass=%b expected 1/3/0", err_s, stim_s, pass_s); end
    checks++; if ({fv_s, fm_s} !== {4'h3, 15'h0004}) begin errors++;
      $display("FAIL sof_capture: got fv=%0h fm=%0h expected 3/0004", fv_s, fm_s); end
    repeat (48) @(negedge clk);
    mode_s = 0;
  endtask

  task automatic test_reset_mid();
    int cycles = 0;
    pulse_start();
    while (stim_a !== 4'h7 && cycles < 200) begin @(negedge clk); cycles++; end
    checks++; if (stim_a !== 4'h7) begin errors++;
      $display("FAIL mid_reach_vec7: got stim=%0h expected 7", stim_a); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({stim_a, busy_a, done_a, pass_a, err_a, fv_a, fm_a} !== 31'd0) begin errors++;
      $display("FAIL mid_reset: got stim=%0h busy=%b done=%b err=%0d fv=%0h fm=%0h expected all 0",
               stim_a, busy_a, done_a, err_a, fv_a, fm_a); end
    repeat (4) @(negedge clk);
    checks++; if ({stim_a, busy_a} !== 5'd0) begin errors++;
      $display("FAIL mid_stay_idle: got stim=%0h busy=%b expected 0/0", stim_a, busy_a); end
  endtask

  task automatic test_start_while_busy();
    int cycles = 0;
    pulse_start();
    repeat (10) begin @(negedge clk); cycles++; end
    start = 1'b1;
    @(negedge clk); cycles++;
    start = 1'b0;
    while (!done_a && cycles < 200) begin @(negedge clk); cycles++; end
    checks++; if (cycles !== 48) begin errors++;
      $display("FAIL busy_start_latency: got %0d cycles expected 48", cycles); end
    checks++; if ({pass_a, stim_a} !== {1'b1, 4'hF}) begin errors++;
      $display("FAIL busy_start_result: got pass=%b stim=%0h expected 1/f", pass_a, stim_a); end
  endtask

  task automatic test_back_to_back();
    int cycles = 0;
    mode_a = 1;
    pulse_start();
    while (!done_a && cycles < 200) begin @(negedge clk); cycles++; end
    checks++; if (err_a !== 5'd8) begin errors++;
      $display("FAIL b2b_first_err: got %0d expected 8", err_a); end
    mode_a = 0;
    pulse_start();
    checks++; if ({done_a, busy_a, err_a, fv_a, fm_a} !== {2'b01, 24'd0}) begin errors++;
      $display("FAIL b2b_cleared: got done=%b busy=%b err=%0d fv=%0h fm=%0h expected 0/1/0/0/0",
               done_a, busy_a, err_a, fv_a, fm_a); end
    cycles = 0;
    while (!done_a && cycles < 200) begin @(negedge clk); cycles++; end
    checks++; if (cycles !== 48) begin errors++;
      $display("FAIL b2b_latency: got %0d cycles expected 48", cycles); end
    checks++; if ({pass_a, err_a} !== {1'b1, 5'd0}) begin errors++;
      $display("FAIL b2b_pass: got pass=%b err=%0d expected 1/0", pass_a, err_a); end
  endtask

  initial begin
    checks = 0; errors = 0;
    mode_a = 0; mode_m = 0; mode_s = 0;
    rst_n = 1'b0; start = 1'b0;
    test_reset();
    test_clean();
    test_xor_stuck();
    test_aoi4_masked();
    test_stop_on_fail();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
